// File: rtl/mac_result_tx.sv
// mac_result_tx: queues MAC results in a small FIFO and streams each one as a 3-byte frame.
// Build macro MAC_TX_SAT_EN clamps results to the 16-bit signed range before they are queued.
module mac_result_tx #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               res_valid_i,
    input  logic signed [16:0] res_data_i,
    input  logic               res_mode_i,
    output logic [7:0]         byte_out_o,
    output logic               byte_valid_o,
    input  logic               byte_ready_i,
    output logic               frame_last_o,
    output logic               fifo_full_o,
    output logic               fifo_empty_o,
    output logic [7:0]         drop_count_o
);
    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    // Returns {sat, data[16:0]}; sat marks a result that had to be clamped.
    function automatic logic [17:0] sat_clamp(input logic signed [16:0] din);
`ifdef MAC_TX_SAT_EN
        if (din > 17'sd32767) begin
            return {1'b1, 17'h07FFF};
        end else if (din < -17'sd32768) begin
            return {1'b1, 17'h18000};
        end else begin
            return {1'b0, din};
        end
`else
        return {1'b0, din};
`endif
    endfunction

    // Entry layout: {mode, sat, data[16:0]}
    logic [18:0]       mem_q [DEPTH];
    logic [18:0]       frame_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic [7:0]        drop_q;
    state_t            state_q;
    state_t            state_d;
    logic              push;
    logic              pop;
    logic [17:0]       clamped;

    assign fifo_full_o  = (count_q == CNT_FULL);
    assign fifo_empty_o = (count_q == '0);
    assign drop_count_o = drop_q;
    assign clamped      = sat_clamp(res_data_i);
    // Full blocks the push even if the FSM pops in the same cycle.
    assign push         = res_valid_i && !fifo_full_o;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        byte_valid_o = 1'b0;
        byte_out_o   = 8'h00;
        frame_last_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_o) begin
                    pop     = 1'b1;
                    state_d = B0;
                end
            end
            B0: begin
                byte_valid_o = 1'b1;
                byte_out_o   = {frame_q[18], 5'b00000, frame_q[17], frame_q[16]};
                if (byte_ready_i) begin
                    state_d = B1;
                end
            end
            B1: begin
                byte_valid_o = 1'b1;
                byte_out_o   = frame_q[15:8];
                if (byte_ready_i) begin
                    state_d = B2;
                end
            end
            B2: begin
                byte_valid_o = 1'b1;
                byte_out_o   = frame_q[7:0];
                frame_last_o = 1'b1;
                if (byte_ready_i) begin
                    // Chain straight into the next frame when one is waiting.
                    if (!fifo_empty_o) begin
                        pop     = 1'b1;
                        state_d = B0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (res_valid_i && fifo_full_o && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {res_mode_i, clamped};
        end
        if (pop) begin
            frame_q <= mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_mac_result_tx.sv
// Directed bench for mac_result_tx: cycle table for single/back-to-back/large-value frames,
// plus hand sequences for backpressure, overflow with drop counting, and reset mid-frame.
module tb_mac_result_tx;
    logic               clk = 1'b0;
    logic               reset;
    logic               res_valid;
    logic signed [16:0] res_data;
    logic               res_mode;
    logic [7:0]         byte_out;
    logic               byte_valid;
    logic               byte_ready;
    logic               frame_last;
    logic               fifo_full;
    logic               fifo_empty;
    logic [7:0]         drop_count;

    int n_vec  = 0;
    int n_fail = 0;

    mac_result_tx #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .res_valid_i  (res_valid),
        .res_data_i   (res_data),
        .res_mode_i   (res_mode),
        .byte_out_o   (byte_out),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready),
        .frame_last_o (frame_last),
        .fifo_full_o  (fifo_full),
        .fifo_empty_o (fifo_empty),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               v;
        logic signed [16:0] d;
        logic               m;
        logic               r;
        logic               ebv;
        logic [7:0]         eb;
        logic               el;
        logic               ee;
    } vec_t;

    vec_t vq[$];

`ifdef MAC_TX_SAT_EN
    localparam logic [7:0] P0 = 8'h02, P1 = 8'h7F, P2 = 8'hFF;
    localparam logic [7:0] N0 = 8'h03, N1 = 8'h80, N2 = 8'h00;
`else
    localparam logic [7:0] P0 = 8'h00, P1 = 8'h9C, P2 = 8'h40;
    localparam logic [7:0] N0 = 8'h01, N1 = 8'h63, N2 = 8'hC0;
`endif

    function automatic logic [19:0] pk(input logic bv, input logic last, input logic full,
                                       input logic empty, input logic [7:0] b, input logic [7:0] drop);
        return {bv, last, full, empty, b, drop};
    endfunction

    function automatic logic [19:0] obs();
        return {byte_valid, frame_last, fifo_full, fifo_empty, byte_out, drop_count};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {bv,last,full,empty,byte,drop}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input int din, input logic m, input logic r,
                       input logic ebv, input logic [7:0] eb, input logic el, input logic ee);
        vec_t t;
        t.v = v; t.d = 17'(din); t.m = m; t.r = r;
        t.ebv = ebv; t.eb = eb; t.el = el; t.ee = ee;
        vq.push_back(t);
    endtask

    task automatic drive(input logic v, input int din, input logic m, input logic r);
        res_valid  = v;
        res_data   = 17'(din);
        res_mode   = m;
        byte_ready = r;
    endtask

    initial begin
        logic [7:0] exp_b [15];

        reset = 1'b1;
        drive(0, 0, 0, 0);
        #3;
        check("reset_state", obs(), pk(0, 0, 0, 1, 8'h00, 8'h00));
        @(negedge clk);
        reset = 1'b0;

        // single frame (-7, trinomial), back-to-back SumP 100/-1, large values
        add(1, -7, 1, 1,  0, 8'h00, 0, 0);
        add(0, 0, 0, 1,   1, 8'h81, 0, 1);
        add(0, 0, 0, 1,   1, 8'hFF, 0, 1);
        add(0, 0, 0, 1,   1, 8'hF9, 1, 1);
        add(0, 0, 0, 1,   0, 8'h00, 0, 1);
        add(1, 100, 0, 1, 0, 8'h00, 0, 0);
        add(1, -1, 0, 1,  1, 8'h00, 0, 0);
        add(0, 0, 0, 1,   1, 8'h00, 0, 0);
        add(0, 0, 0, 1,   1, 8'h64, 1, 0);
        add(0, 0, 0, 1,   1, 8'h01, 0, 1);
        add(0, 0, 0, 1,   1, 8'hFF, 0, 1);
        add(0, 0, 0, 1,   1, 8'hFF, 1, 1);
        add(0, 0, 0, 1,   0, 8'h00, 0, 1);
        add(1, 40000, 0, 1,  0, 8'h00, 0, 0);
        add(0, 0, 0, 1,   1, P0, 0, 1);
        add(0, 0, 0, 1,   1, P1, 0, 1);
        add(0, 0, 0, 1,   1, P2, 1, 1);
        add(1, -40000, 0, 1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 1,   1, N0, 0, 1);
        add(0, 0, 0, 1,   1, N1, 0, 1);
        add(0, 0, 0, 1,   1, N2, 1, 1);
        add(0, 0, 0, 1,   0, 8'h00, 0, 1);

        foreach (vq[i]) begin
            drive(vq[i].v, int'(vq[i].d), vq[i].m, vq[i].r);
            step();
            check($sformatf("vec%0d", i), obs(),
                  pk(vq[i].ebv, vq[i].el, 1'b0, vq[i].ee, vq[i].eb, 8'h00));
        end

        // backpressure on byte1
        drive(1, 32'h0A55B, 0, 1);
        step();
        drive(0, 0, 0, 1);
        step();
        check("bp_b0", obs(), pk(1, 0, 0, 1, 8'h00, 8'h00));
        step();
        check("bp_b1", obs(), pk(1, 0, 0, 1, 8'hA5, 8'h00));
        byte_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp_hold%0d", k), obs(), pk(1, 0, 0, 1, 8'hA5, 8'h00));
        end
        byte_ready = 1'b1;
        step();
        check("bp_b2", obs(), pk(1, 1, 0, 1, 8'h5B, 8'h00));
        step();
        check("bp_idle", obs(), pk(0, 0, 0, 1, 8'h00, 8'h00));

        // overflow: six results with the sink stalled
        byte_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1, i * 257, i[0], 0);
            step();
            if (i == 1) check("ovf_r1", obs(), pk(0, 0, 0, 0, 8'h00, 8'h00));
            if (i == 5) check("ovf_full", obs(), pk(1, 0, 1, 0, 8'h80, 8'h00));
            if (i == 6) check("ovf_drop", obs(), pk(1, 0, 1, 0, 8'h80, 8'h01));
        end
        for (int i = 1; i <= 5; i++) begin
            exp_b[3*i-3] = {i[0], 7'b0000000};
            exp_b[3*i-2] = 8'(i);
            exp_b[3*i-1] = 8'(i);
        end
        drive(0, 0, 0, 1);
        for (int j = 0; j < 15; j++) begin
            check($sformatf("drain%0d", j), {byte_valid, frame_last, byte_out},
                  {1'b1, (j % 3) == 2, exp_b[j]});
            step();
        end
        check("drain_idle", obs(), pk(0, 0, 0, 1, 8'h00, 8'h01));

        // reset during byte1, with another result queued
        drive(1, 32'h01234, 1, 1);
        step();
        drive(0, 0, 0, 1);
        step();
        check("rst_b0", obs(), pk(1, 0, 0, 1, 8'h80, 8'h01));
        step();
        check("rst_b1", obs(), pk(1, 0, 0, 1, 8'h12, 8'h01));
        drive(1, 5, 0, 0);
        step();
        check("rst_queued", obs(), pk(1, 0, 0, 0, 8'h12, 8'h01));
        drive(0, 0, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", obs(), pk(0, 0, 0, 1, 8'h00, 8'h00));
        @(negedge clk);
        reset = 1'b0;
        byte_ready = 1'b1;
        step();
        check("rst_aborted", obs(), pk(0, 0, 0, 1, 8'h00, 8'h00));
        drive(1, -2, 0, 1);
        step();
        drive(0, 0, 0, 1);
        step();
        check("post_b0", obs(), pk(1, 0, 0, 1, 8'h01, 8'h00));
        step();
        check("post_b1", obs(), pk(1, 0, 0, 1, 8'hFF, 8'h00));
        step();
        check("post_b2", obs(), pk(1, 1, 0, 1, 8'hFE, 8'h00));
        step();
        check("post_idle", obs(), pk(0, 0, 0, 1, 8'h00, 8'h00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
